uart_rx_param: RTL and testbench
================================

UART_RX_PARAM -- requirements
Module: uart_rx_param

Interface
REQ-001 Parameter DATA_WIDTH, 8, number of data bits per frame; legal range 5..9.
REQ-002 Parameter PRESCALE_W, 6, width of the Prescale port.
REQ-003 Port CLK  input  1  single receiver clock, oversampling the serial line.
REQ-004 Port RST  input  1  reset; asynchronous, active-high.
REQ-005 Port RX_IN  input  1  serial line; idles high; asynchronous to CLK.
REQ-006 Port Prescale  input  PRESCALE_W  CLK cycles per bit.
REQ-007 Port PAR_EN  input  1  1 = parity bit present after the data bits.
REQ-008 Port PAR_TYP  input  1  0 = even parity, 1 = odd parity.
REQ-009 Port STOP_2  input  1  1 = two stop bits, 0 = one stop bit.
REQ-010 Port P_DATA  output  DATA_WIDTH  last correctly received data word.
REQ-011 Port data_valid  output  1  one-cycle pulse: P_DATA holds a new error-free word.
REQ-012 Port Parity_Error  output  1  one-cycle pulse: the frame failed the parity check.
REQ-013 Port Stop_error  output  1  one-cycle pulse: a stop bit was sampled low.
REQ-014 Port busy  output  1  high while the FSM is not in IDLE.

Function
REQ-015 RX_IN SHALL pass through a 2-flop synchronizer; all logic below uses the synchronized value (rx_s).
REQ-016 The FSM SHALL have states IDLE, START, DATA, PARITY, STOP, DONE.
REQ-017 In IDLE, rx_s == 0 SHALL move the FSM to START with edge_cnt = 0 and bit_cnt = 0.
REQ-018 Prescale, PAR_EN, PAR_TYP and STOP_2 SHALL be latched on the IDLE->START transition; changes mid-frame SHALL be ignored.
REQ-019 Latched Prescale SHALL have its LSB forced to 0, and any value below 4 SHALL be replaced by 4.
REQ-020 edge_cnt SHALL count 0..P-1 (P = latched prescale) within each bit, then wrap to 0 and increment bit_cnt.
REQ-021 Each bit SHALL be sampled at edge_cnt = P/2-1, P/2 and P/2+1, and the bit value SHALL be the 2-of-3 majority of those samples.
REQ-022 START: if the start bit majority is 1, the frame SHALL be treated as a glitch: go to IDLE at the end of the start bit with no output pulse.
REQ-023 START: if the start bit majority is 0, the FSM SHALL go to DATA.
REQ-024 DATA SHALL shift in DATA_WIDTH bits LSB first.
REQ-025 After DATA, the FSM SHALL go to PARITY if PAR_EN, else to STOP.
REQ-026 PARITY: the received bit SHALL be compared with the XOR of the data bits, inverted when PAR_TYP = 1; a mismatch SHALL set an internal par_err flag.
REQ-027 STOP SHALL cover 1 or 2 bit periods per the latched STOP_2; any stop bit sampled 0 SHALL set an internal stp_err flag.
REQ-028 The FSM SHALL enter DONE on the cycle after the final stop bit reaches edge_cnt = P-1, and DONE SHALL last exactly one cycle.
REQ-029 In DONE with no errors: P_DATA SHALL load the shifted word and data_valid SHALL be 1 for that cycle.
REQ-030 In DONE with errors: the matching error pulses SHALL be 1, P_DATA SHALL hold its old value, and data_valid SHALL be 0.
REQ-031 Parity_Error and Stop_error MAY assert together in DONE.
REQ-032 DONE SHALL go to START if rx_s == 0 in that cycle (back-to-back frames), else to IDLE.
REQ-033 P_DATA SHALL remain stable except during a valid DONE cycle.
REQ-034 Nominal latency from the start-bit falling edge on RX_IN to data_valid SHALL be 2 + P*(1+DATA_WIDTH+PAR_EN+1+STOP_2) + 1 cycles.

Reset
REQ-035 While RST = 1: FSM = IDLE; edge_cnt, bit_cnt and the shift register = 0; synchronizer flops = 1.
REQ-036 While RST = 1: P_DATA = 0 and data_valid = Parity_Error = Stop_error = busy = 0.
REQ-037 Reset asserted mid-frame SHALL abort the frame with no output pulse.
REQ-038 After reset release, the block SHALL wait for a fresh falling edge; a line already low SHALL start a frame only after it is seen low in IDLE.

Verification
REQ-039 DATA_WIDTH=8, P=8, PAR_EN=1, PAR_TYP=0, STOP_2=0, frame 0xA5 with correct parity -> one data_valid pulse, P_DATA=0xA5, no errors, latency 2+8*11+1 cycles.
REQ-040 Same config with the parity bit flipped -> Parity_Error pulse, data_valid=0, P_DATA unchanged from the previous value.
REQ-041 P=16, STOP_2=1, frame 0x3C with the second stop bit low -> Stop_error pulse only, and the block accepts the next frame.
REQ-042 RX_IN low for 3 cycles at P=16 -> glitch, no pulses, busy returns to 0 after 16 cycles.
REQ-043 DATA_WIDTH=5, P=4, two back-to-back frames 0x15 then 0x0A with no idle gap -> two data_valid pulses with the correct words.
REQ-044 RST pulsed mid-DATA, then a clean 0x5A frame -> all outputs 0 during reset, then P_DATA=0x5A and one data_valid pulse.

Source files
------------

// File: rtl/uart_rx_param.sv
// Oversampling UART receiver: configurable width, prescale, parity and stop bits.
// Each bit is decided by a 2-of-3 majority vote around its mid-point.
module uart_rx_param #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic [PRESCALE_W-1:0] Prescale,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  STOP_2,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  data_valid,
  output logic                  Parity_Error,
  output logic                  Stop_error,
  output logic                  busy
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;
  localparam logic [2:0] DONE   = 3'd5;

  logic                  rx_meta_q, rx_s_q;
  logic [2:0]            state_q, state_d;
  logic [PRESCALE_W-1:0] edge_q, edge_d;
  logic [3:0]            bit_q, bit_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [1:0]            samp_q, samp_d;
  logic                  bitval_q, bitval_d;
  logic                  par_err_q, par_err_d;
  logic                  stp_err_q, stp_err_d;
  logic [PRESCALE_W-1:0] p_q, p_d;
  logic                  par_en_q, par_en_d;
  logic                  par_typ_q, par_typ_d;
  logic                  stop2_q, stop2_d;
  logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
  logic                  dv_q, dv_d;
  logic                  pe_q, pe_d;
  logic                  se_q, se_d;

  logic [PRESCALE_W-1:0] half, p_in;
  logic                  maj, at_vote, bit_end, bit_now, start_frame;

  assign half    = p_q >> 1;
  assign maj     = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s_q) | (samp_q[1] & rx_s_q);
  assign at_vote = (edge_q == half + PRESCALE_W'(1));
  assign bit_end = (edge_q == p_q - PRESCALE_W'(1));
  // With P=4 the vote lands on the last cycle of the bit, so use it directly.
  assign bit_now = at_vote ? maj : bitval_q;

  always_comb begin
    p_in = Prescale & ~PRESCALE_W'(1);
    if (p_in < PRESCALE_W'(4)) p_in = PRESCALE_W'(4);
  end

  always_comb begin
    state_d     = state_q;
    edge_d      = edge_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    samp_d      = samp_q;
    bitval_d    = bitval_q;
    par_err_d   = par_err_q;
    stp_err_d   = stp_err_q;
    p_d         = p_q;
    par_en_d    = par_en_q;
    par_typ_d   = par_typ_q;
    stop2_d     = stop2_q;
    p_data_d    = p_data_q;
    dv_d        = 1'b0;
    pe_d        = 1'b0;
    se_d        = 1'b0;
    start_frame = 1'b0;

    if (state_q != IDLE && state_q != DONE) begin
      edge_d = bit_end ? '0 : edge_q + PRESCALE_W'(1);
      if (edge_q == half - PRESCALE_W'(1)) samp_d[0] = rx_s_q;
      if (edge_q == half)                  samp_d[1] = rx_s_q;
      if (at_vote)                         bitval_d  = maj;
    end

    case (state_q)
      IDLE: if (!rx_s_q) start_frame = 1'b1;
      START: begin
        if (bit_end) begin
          bit_d   = '0;
          state_d = bit_now ? IDLE : DATA;
        end
      end
      DATA: begin
        if (at_vote) shift_d = {maj, shift_q[DATA_WIDTH-1:1]};
        if (bit_end) begin
          if (bit_q == 4'(DATA_WIDTH - 1)) begin
            bit_d   = '0;
            state_d = par_en_q ? PARITY : STOP;
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end
      end
      PARITY: begin
        if (at_vote && (maj != ((^shift_q) ^ par_typ_q))) par_err_d = 1'b1;
        if (bit_end) begin
          bit_d   = '0;
          state_d = STOP;
        end
      end
      STOP: begin
        if (at_vote && !maj) stp_err_d = 1'b1;
        if (bit_end) begin
          if (bit_q == {3'b000, stop2_q}) begin
            state_d = DONE;
            dv_d    = !par_err_d && !stp_err_d;
            pe_d    = par_err_d;
            se_d    = stp_err_d;
            if (dv_d) p_data_d = shift_q;
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end
      end
      DONE: begin
        if (!rx_s_q) start_frame = 1'b1;
        else         state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (start_frame) begin
      state_d   = START;
      // From DONE the start bit is already one cycle old; keep bit timing aligned.
      edge_d    = (state_q == DONE) ? PRESCALE_W'(1) : '0;
      bit_d     = '0;
      par_err_d = 1'b0;
      stp_err_d = 1'b0;
      p_d       = p_in;
      par_en_d  = PAR_EN;
      par_typ_d = PAR_TYP;
      stop2_d   = STOP_2;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      state_q   <= IDLE;
      edge_q    <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      samp_q    <= '1;
      bitval_q  <= 1'b1;
      par_err_q <= 1'b0;
      stp_err_q <= 1'b0;
      p_q       <= PRESCALE_W'(4);
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      stop2_q   <= 1'b0;
      p_data_q  <= '0;
      dv_q      <= 1'b0;
      pe_q      <= 1'b0;
      se_q      <= 1'b0;
    end else begin
      rx_meta_q <= RX_IN;
      rx_s_q    <= rx_meta_q;
      state_q   <= state_d;
      edge_q    <= edge_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      samp_q    <= samp_d;
      bitval_q  <= bitval_d;
      par_err_q <= par_err_d;
      stp_err_q <= stp_err_d;
      p_q       <= p_d;
      par_en_q  <= par_en_d;
      par_typ_q <= par_typ_d;
      stop2_q   <= stop2_d;
      p_data_q  <= p_data_d;
      dv_q      <= dv_d;
      pe_q      <= pe_d;
      se_q      <= se_d;
    end
  end

  assign P_DATA       = p_data_q;
  assign data_valid   = dv_q;
  assign Parity_Error = pe_q;
  assign Stop_error   = se_q;
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// Scoreboard bench for uart_rx_param: 8-bit and 5-bit receivers on one clock.
`timescale 1ns/1ps
module tb_uart_rx_param;

  typedef struct packed {
    logic [8:0] data;
    logic       pe;
    logic       se;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx8 = 1'b1;
  logic       rx5 = 1'b1;
  logic [5:0] prescale = 6'd8;
  logic       par_en = 1'b1;
  logic       par_typ = 1'b0;
  logic       stop2 = 1'b0;

  logic [7:0] pdata8;
  logic       dv8, pe8, se8, busy8;
  logic [4:0] pdata5;
  logic       dv5, pe5, se5, busy5;

  int   checks = 0;
  int   failures = 0;
  exp_t q8[$];
  exp_t q5[$];
  logic [7:0] last_good8 = '0;
  logic [4:0] last_good5 = '0;

  always #5 clk = ~clk;

  uart_rx_param #(.DATA_WIDTH(8), .PRESCALE_W(6)) u_dut8 (
    .CLK(clk), .RST(rst), .RX_IN(rx8), .Prescale(prescale),
    .PAR_EN(par_en), .PAR_TYP(par_typ), .STOP_2(stop2),
    .P_DATA(pdata8), .data_valid(dv8), .Parity_Error(pe8),
    .Stop_error(se8), .busy(busy8)
  );

  uart_rx_param #(.DATA_WIDTH(5), .PRESCALE_W(6)) u_dut5 (
    .CLK(clk), .RST(rst), .RX_IN(rx5), .Prescale(prescale),
    .PAR_EN(par_en), .PAR_TYP(par_typ), .STOP_2(stop2),
    .P_DATA(pdata5), .data_valid(dv5), .Parity_Error(pe5),
    .Stop_error(se5), .busy(busy5)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drives one frame on rx8 (which=0) or rx5 (which=1); call on a negedge.
  task automatic send_frame(input bit which, input int dw, input logic [8:0] data,
                            input int p, input bit pen, input bit ptyp, input bit s2,
                            input bit flip_par, input logic [1:0] stop_low);
    logic [15:0] bits;
    int          n;
    logic        par;
    bits    = '1;
    bits[0] = 1'b0;
    par     = ptyp;
    for (int i = 0; i < dw; i++) begin
      bits[1+i] = data[i];
      par       = par ^ data[i];
    end
    n = 1 + dw;
    if (pen) begin
      bits[n] = par ^ flip_par;
      n++;
    end
    bits[n] = ~stop_low[0];
    n++;
    if (s2) begin
      bits[n] = ~stop_low[1];
      n++;
    end
    for (int i = 0; i < n; i++) begin
      if (which) rx5 = bits[i];
      else       rx8 = bits[i];
      repeat (p) @(negedge clk);
    end
    rx8 = 1'b1;
    rx5 = 1'b1;
  endtask

  task automatic push8(input logic [7:0] d, input bit pe, input bit se);
    exp_t e;
    e.data = {1'b0, d};
    e.pe   = pe;
    e.se   = se;
    q8.push_back(e);
  endtask

  task automatic push5(input logic [4:0] d);
    exp_t e;
    e.data = {4'b0, d};
    e.pe   = 1'b0;
    e.se   = 1'b0;
    q5.push_back(e);
  endtask

  task automatic drain(input string tag);
    int t;
    t = 0;
    while ((q8.size() != 0 || q5.size() != 0) && t < 2000) begin
      @(negedge clk);
      t++;
    end
    chk(tag, q8.size() + q5.size(), 0);
    repeat (10) @(negedge clk);
  endtask

  task automatic measure_latency(input int expected);
    int lat;
    bit seen;
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 400) begin
      @(posedge clk);
      #1;
      lat++;
      if (dv8) seen = 1'b1;
    end
    chk("latency", lat, expected);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_pdata8"}, pdata8, 0);
    chk({tag, "_dv8"}, dv8, 0);
    chk({tag, "_pe8"}, pe8, 0);
    chk({tag, "_se8"}, se8, 0);
    chk({tag, "_busy8"}, busy8, 0);
    chk({tag, "_pdata5"}, pdata5, 0);
    chk({tag, "_dv5"}, dv5, 0);
    chk({tag, "_pe5"}, pe5, 0);
    chk({tag, "_se5"}, se5, 0);
    chk({tag, "_busy5"}, busy5, 0);
  endtask

  always @(negedge clk) begin : mon8
    exp_t e;
    if (!rst && (dv8 || pe8 || se8)) begin
      if (q8.size() == 0) begin
        chk("unexpected_pulse8", 1, 0);
      end else begin
        e = q8.pop_front();
        chk("dv8", dv8, !(e.pe || e.se));
        chk("pe8", pe8, e.pe);
        chk("se8", se8, e.se);
        chk("pdata8", pdata8, (e.pe || e.se) ? last_good8 : e.data[7:0]);
        if (!(e.pe || e.se)) last_good8 = e.data[7:0];
      end
    end
  end

  always @(negedge clk) begin : mon5
    exp_t e;
    if (!rst && (dv5 || pe5 || se5)) begin
      if (q5.size() == 0) begin
        chk("unexpected_pulse5", 1, 0);
      end else begin
        e = q5.pop_front();
        chk("dv5", dv5, 1);
        chk("pe5", pe5, 0);
        chk("se5", se5, 0);
        chk("pdata5", pdata5, e.data[4:0]);
        last_good5 = e.data[4:0];
      end
    end
  end

  initial begin
    int busy_cnt;

    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Valid 0xA5, P=8, even parity, latency check
    prescale = 6'd8; par_en = 1'b1; par_typ = 1'b0; stop2 = 1'b0;
    push8(8'hA5, 1'b0, 1'b0);
    fork
      send_frame(1'b0, 8, 9'h0A5, 8, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
      measure_latency(2 + 8 * 11 + 1);
    join
    drain("drain_a5");

    // Flipped parity: P_DATA must keep 0xA5
    push8(8'h5A, 1'b1, 1'b0);
    send_frame(1'b0, 8, 9'h05A, 8, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00);
    drain("drain_parerr");

    // P=16, two stop bits, second one low
    prescale = 6'd16; stop2 = 1'b1;
    push8(8'h3C, 1'b0, 1'b1);
    send_frame(1'b0, 8, 9'h03C, 16, 1'b1, 1'b0, 1'b1, 1'b0, 2'b10);
    drain("drain_stoperr");

    // Next frame accepted; config changed mid-frame must be ignored
    par_typ = 1'b1;
    push8(8'hC3, 1'b0, 1'b0);
    fork
      send_frame(1'b0, 8, 9'h0C3, 16, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00);
      begin
        repeat (40) @(negedge clk);
        prescale = 6'd8; par_typ = 1'b0; stop2 = 1'b0;
      end
    join
    drain("drain_after_stoperr");

    // Glitch: 3 cycles low at P=16
    prescale = 6'd16; par_typ = 1'b0; stop2 = 1'b0;
    busy_cnt = 0;
    rx8 = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (busy8) busy_cnt++;
    end
    rx8 = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (busy8) busy_cnt++;
    end
    chk("glitch_busy_cycles", busy_cnt, 16);
    chk("glitch_busy_end", busy8, 0);

    // DATA_WIDTH=5, P=4, back-to-back frames
    prescale = 6'd4; par_en = 1'b0; stop2 = 1'b0;
    push5(5'h15);
    push5(5'h0A);
    send_frame(1'b1, 5, 9'h015, 4, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
    send_frame(1'b1, 5, 9'h00A, 4, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
    drain("drain_b2b");

    // Reset mid-DATA, then a clean 0x5A
    prescale = 6'd8; par_en = 1'b1; par_typ = 1'b0; stop2 = 1'b0;
    rx8 = 1'b0;
    repeat (8) @(negedge clk);
    rx8 = 1'b1;
    repeat (12) @(negedge clk);
    chk("busy_mid_frame", busy8, 1);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_all_zero("midreset");
    last_good8 = '0;
    last_good5 = '0;
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("busy_after_reset", busy8, 0);
    push8(8'h5A, 1'b0, 1'b0);
    send_frame(1'b0, 8, 9'h05A, 8, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
    drain("drain_after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
